// File: rtl/ofm_writeback.sv
// OFM write-back stage: per-lane result FIFOs drained round-robin onto a single
// OFM write port, with per-lane address generation and a completion pulse.
module ofm_writeback #(
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int ADR_W  = 7,
    parameter int DATA_W = 32,
    parameter int STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADR_W-1:0]      base,
    input  logic [7:0]            cnt,
    input  logic [N-1:0]          inValid,
    input  logic [N*DATA_W-1:0]   inData,
    output logic [N-1:0]          inReady,
    output logic                  wrEn,
    output logic [ADR_W-1:0]      wrAdr,
    output logic [DATA_W-1:0]     wrData,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t              r_state, w_state_next;
    logic [ADR_W-1:0]    r_base;
    logic [7:0]          r_lim;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_wr_en;
    logic [ADR_W-1:0]    r_wr_adr;
    logic [DATA_W-1:0]   r_wr_data;

    logic                w_start_ok;
    logic [N-1:0]        w_push, w_pop, w_nonempty, w_lane_done, w_req2;
    logic [N*DATA_W-1:0] w_head_flat;
    logic [N*8-1:0]      w_wr_flat;
    logic                w_gnt_vld;
    logic [IDX_W:0]      w_gnt_sum;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [7:0]          w_gnt_wr;
    logic [ADR_W-1:0]    w_gnt_adr;
    logic [DATA_W-1:0]   w_gnt_data;

    assign w_start_ok = (r_state == S_IDLE) && start;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wp, r_rp;
            logic [OCC_W-1:0]  r_occ;
            logic [7:0]        r_acc, r_wr;

            // Ready is purely registered so upstream never sees a combinational loop.
            assign inReady[gi]     = (r_state == S_RUN) && (r_occ != OCC_W'(DEPTH)) && (r_acc < r_lim);
            assign w_push[gi]      = inValid[gi] && inReady[gi];
            assign w_pop[gi]       = w_gnt_vld && (w_gnt_idx == IDX_W'(gi));
            assign w_nonempty[gi]  = (r_occ != '0);
            assign w_lane_done[gi] = (r_wr == r_lim);
            assign w_head_flat[gi*DATA_W +: DATA_W] = r_mem[r_rp];
            assign w_wr_flat[gi*8 +: 8] = r_wr;

            always_ff @(posedge clk) begin
                if (w_push[gi]) r_mem[r_wp] <= inData[gi*DATA_W +: DATA_W];
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_occ <= '0;
                    r_acc <= '0;
                    r_wr  <= '0;
                end else if (w_start_ok) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_occ <= '0;
                    r_acc <= '0;
                    r_wr  <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wp  <= r_wp + PTR_W'(1);
                        r_acc <= r_acc + 8'd1;
                    end
                    if (w_pop[gi]) begin
                        r_rp <= r_rp + PTR_W'(1);
                        r_wr <= r_wr + 8'd1;
                    end
                    r_occ <= r_occ + OCC_W'(w_push[gi]) - OCC_W'(w_pop[gi]);
                end
            end
        end
    endgenerate

    // Rotate requests so bit 0 is the pointer lane; lowest set bit wins.
    always_comb begin
        w_req2    = N'({w_nonempty, w_nonempty} >> r_ptr);
        w_gnt_vld = 1'b0;
        w_gnt_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req2[k] && (r_state == S_RUN)) begin
                w_gnt_vld = 1'b1;
                w_gnt_sum = {1'b0, r_ptr} + (IDX_W + 1)'(k);
            end
        end
        if (w_gnt_sum >= (IDX_W + 1)'(N)) w_gnt_sum = w_gnt_sum - (IDX_W + 1)'(N);
        w_gnt_idx = w_gnt_sum[IDX_W-1:0];
    end

    assign w_gnt_wr   = w_wr_flat[w_gnt_idx*8 +: 8];
    assign w_gnt_data = w_head_flat[w_gnt_idx*DATA_W +: DATA_W];
    assign w_gnt_adr  = r_base + ADR_W'(w_gnt_idx) * ADR_W'(STRIDE) + ADR_W'(w_gnt_wr);

    // Lane write counters update at the grant edge, so all-done coincides with the final wrEn cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (&w_lane_done) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_lim     <= '0;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_base <= base;
                r_lim  <= cnt;
            end
            r_wr_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_wr_adr  <= w_gnt_adr;
                r_wr_data <= w_gnt_data;
                r_ptr     <= (w_gnt_idx == IDX_W'(N - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
            end
        end
    end

    assign wrEn   = r_wr_en;
    assign wrAdr  = r_wr_adr;
    assign wrData = r_wr_data;
    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_FIN);
endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: table of directed operations, hand-written
// corner sequences and randomized operations against a per-lane expected-write model.
module tb_ofm_writeback;
    localparam int N = 4, DEPTH = 4, ADR_W = 7, DATA_W = 32, STRIDE = 4;

    logic                clk = 1'b0, rstn = 1'b1, start = 1'b0;
    logic [ADR_W-1:0]    base = '0;
    logic [7:0]          cnt = '0;
    logic [N-1:0]        inValid = '0;
    logic [N*DATA_W-1:0] inData = '0;
    logic [N-1:0]        inReady;
    logic                wrEn, busy, done;
    logic [ADR_W-1:0]    wrAdr;
    logic [DATA_W-1:0]   wrData;

    ofm_writeback #(.N(N), .DEPTH(DEPTH), .ADR_W(ADR_W), .DATA_W(DATA_W), .STRIDE(STRIDE)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .cnt(cnt),
        .inValid(inValid), .inData(inData), .inReady(inReady),
        .wrEn(wrEn), .wrAdr(wrAdr), .wrData(wrData), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    logic [DATA_W-1:0] ldata [N][256];
    int sent [N];
    int widx [N];
    int acc0_cyc [N];
    logic [ADR_W-1:0] cur_base, last_adr;
    int cur_cnt, mode, nwr, ndone, done_cyc, t0, first_wr_cyc;
    logic [N-1:0] en_mask;
    bit over_valid, stall_seen;

    typedef struct {
        logic [ADR_W-1:0] b;
        int               c;
        int               exp_wr;
        logic [ADR_W-1:0] exp_last;
        int               exp_done;
        bit               exp_stall;
        bit               inj;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Each lane's k-th write must go to base + lane*STRIDE + k carrying its k-th accepted datum.
    task automatic sample();
        int lane;
        logic [ADR_W-1:0] ea;
        if (wrEn) begin
            lane = -1;
            for (int i = 0; i < N; i++) begin
                ea = cur_base + ADR_W'(i * STRIDE) + ADR_W'(widx[i]);
                if (lane < 0 && widx[i] < sent[i] && wrAdr == ea && wrData == ldata[i][widx[i]]) lane = i;
            end
            n_chk++;
            if (lane >= 0) begin
                n_pass++;
                if (mode == 0) check("rr_order", lane, nwr % N);
                widx[lane]++;
            end else begin
                $display("FAIL write_match: got adr=%0d data=%h, required a pending lane write", wrAdr, wrData);
            end
            nwr++;
            last_adr = wrAdr;
            if (nwr == 1) first_wr_cyc = cyc;
        end
        if (done) begin
            ndone++;
            if (ndone == 1) done_cyc = cyc - t0;
        end
    endtask

    task automatic step(input bit inj);
        for (int i = 0; i < N; i++) begin
            inValid[i] = en_mask[i] && (over_valid || sent[i] < cur_cnt) &&
                         (mode != 1 || $urandom_range(0, 99) < 60);
            inData[i*DATA_W +: DATA_W] = ldata[i][sent[i]];
        end
        start = inj;
        if (inj) begin
            base = 7'd0;
            cnt  = 8'd1;
        end
        for (int i = 0; i < N; i++) begin
            if (inValid[i] && inReady[i]) begin
                if (sent[i] == 0) acc0_cyc[i] = cyc;
                if (sent[i] < 255) sent[i]++;
            end else if (inValid[i] && sent[i] < cur_cnt) begin
                stall_seen = 1'b1;
            end
        end
        @(negedge clk);
        sample();
    endtask

    task automatic begin_op(input logic [ADR_W-1:0] b, input int c, input int md,
                            input logic [N-1:0] msk, input bit rnd);
        cur_base = b; cur_cnt = c; mode = md; en_mask = msk; over_valid = 1'b0;
        nwr = 0; ndone = 0; done_cyc = -1; first_wr_cyc = -1; stall_seen = 1'b0; last_adr = '0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0; widx[i] = 0; acc0_cyc[i] = -1;
            for (int k = 0; k < 256; k++)
                ldata[i][k] = rnd ? $urandom() : DATA_W'(32'hA0 + i + (k << 8));
        end
        inValid = '0; base = b; cnt = 8'(c); start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        sample();
    endtask

    task automatic run_to_done(input int budget, input bit inj_start);
        int t;
        t = 0;
        while (ndone == 0 && t < budget) begin
            step(inj_start && t == 3);
            t++;
        end
        check("done_within_budget", ndone > 0, 1);
        repeat (4) step(1'b0);
    endtask

    task automatic end_checks();
        check("op_writes", nwr, N * cur_cnt);
        check("op_done_pulses", ndone, 1);
        for (int i = 0; i < N; i++) check("op_lane_drained", widx[i], cur_cnt);
        check("op_idle_busy", busy, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; inValid = '0;
        #1;
        check("rst_wrEn", wrEn, 0);
        check("rst_wrAdr", wrAdr, 0);
        check("rst_wrData", wrData, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_inReady", inReady, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{7'd10,  1, 4,  7'd22, 7,  1'b0, 1'b0};
        vt[1] = '{7'd0,   6, 24, 7'd17, 27, 1'b1, 1'b0};
        vt[2] = '{7'd120, 3, 12, 7'd6,  15, 1'b0, 1'b1};
        vt[3] = '{7'd5,   0, 0,  7'd0,  2,  1'b0, 1'b0};
        vt[4] = '{7'd127, 2, 8,  7'd12, 11, 1'b0, 1'b0};

        #1;
        do_reset();
        @(negedge clk);

        // Reset in the middle of a run with data still queued in the lanes.
        begin_op(7'd20, 5, 0, '1, 1'b1);
        repeat (4) step(1'b0);
        do_reset();
        for (int t = 0; t < 5; t++) begin
            inValid = '1;
            @(negedge clk);
            check("post_rst_wrEn", wrEn, 0);
            check("post_rst_ready", inReady, 0);
            check("post_rst_busy", busy, 0);
        end
        inValid = '0;

        for (int r = 0; r < 5; r++) begin
            begin_op(vt[r].b, vt[r].c, 0, '1, 1'b0);
            run_to_done(200, vt[r].inj);
            check("tbl_writes", nwr, vt[r].exp_wr);
            check("tbl_last_adr", last_adr, vt[r].exp_last);
            check("tbl_done_cyc", done_cyc, vt[r].exp_done);
            check("tbl_full_stall", stall_seen, vt[r].exp_stall);
            end_checks();
        end

        // Lane 2 alone: in-order writes, two-cycle latency, nothing beyond cnt.
        begin_op(7'd40, 3, 2, 4'b0100, 1'b0);
        for (int k = 0; k < 3; k++) ldata[2][k] = DATA_W'(k + 1);
        over_valid = 1'b1;
        repeat (10) step(1'b0);
        check("l2_writes", nwr, 3);
        check("l2_accepts", sent[2], 3);
        check("l2_last_adr", last_adr, 50);
        check("l2_latency", first_wr_cyc - acc0_cyc[2], 2);
        check("l2_ready_low", inReady[2], 0);
        check("l2_busy", busy, 1);
        do_reset();

        // Address wrap-around on lane 0.
        begin_op(7'd126, 3, 2, 4'b0001, 1'b0);
        repeat (10) step(1'b0);
        check("wrap_writes", nwr, 3);
        check("wrap_last_adr", last_adr, 0);
        do_reset();

        for (int r = 0; r < 8; r++) begin
            begin_op(ADR_W'($urandom_range(0, 127)), $urandom_range(0, 9), 1, '1, 1'b1);
            run_to_done(800, 1'b0);
            end_checks();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Downstream stage of the N-PE convolution array.
- Collects the 32-bit results that each PE produces, holds them in a small FIFO per lane, and serialises them onto one single-port OFM write port.
- Round-robin arbitration between lanes; per-lane address generation.
- Reports completion to the controller once every lane has written its expected result count.

Parameters:
- N, 4, number of PE lanes.
- DEPTH, 4, per-lane FIFO depth in entries; power of two, at least 2.
- ADR_W, 7, OFM address width.
- DATA_W, 32, result width.
- STRIDE, 4, address offset between consecutive lanes' base addresses.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; honoured only in IDLE; samples base and cnt.
- base  input  ADR_W  OFM base address of lane 0.
- cnt  input  8  results expected per lane.
- inValid  input  N  lane i offers a result.
- inData  input  N*DATA_W  lane i result in bits [i*DATA_W +: DATA_W].
- inReady  output  N  lane i can accept a result this cycle.
- wrEn  output  1  OFM write strobe.
- wrAdr  output  ADR_W  OFM write address.
- wrData  output  DATA_W  OFM write data.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, while rstn=0: all FIFOs empty; all counters 0; FSM in IDLE; round-robin pointer 0; wrEn=0, wrAdr=0, wrData=0, busy=0, done=0, inReady=0.
- Reset may assert at any time and aborts any operation in progress. No partial write is issued after reset releases.
- FSM states and transitions:
  - IDLE: on start, latch base and cnt, clear all lane counters, go to RUN.
  - RUN: go to FIN on the cycle the final write is issued.
  - FIN: lasts one cycle, then returns to IDLE.
- busy=1 exactly while in RUN. done=1 exactly while in FIN.
- Start handling:
  - start in RUN or FIN is ignored.
  - start with cnt=0 goes IDLE -> RUN -> FIN with no writes, so done pulses 2 cycles after start.
- inReady[i] = RUN && FIFO i not full && acc[i] < cnt. acc[i] is the number of results accepted on lane i (8-bit).
  - inReady depends only on registered state, never on inValid.
- Accept: a result is accepted on lane i at a clock edge where inValid[i] && inReady[i].
  - Accepted data is pushed and acc[i] increments.
  - inValid is ignored while inReady=0; data is not captured.
  - Results beyond cnt are never accepted.
- Arbitration, each RUN cycle:
  - Grant the first non-empty lane, searching from the pointer upward modulo N.
  - Pop its head; after a grant to lane g, the pointer becomes (g+1) mod N.
  - No grant leaves the pointer unchanged.
  - At most one write per cycle.
- Simultaneous push and pop on the same lane in one cycle is legal and leaves occupancy unchanged.
  - A full lane cannot push, even if it is popped in the same cycle.
- Write port:
  - wrEn, wrAdr and wrData are registered.
  - A grant at edge E drives wrEn=1 with the granted data for the cycle after E.
  - wrEn=0 in every cycle without a grant; wrData holds its last value.
- Latency: a result accepted at edge E0 on an otherwise empty, unopposed lane gets its grant at E0+1 and is visible on the write port at E0+2.
- Address:
  - wrAdr = base + i*STRIDE + wr[i], where wr[i] is lane i's count of issued writes.
  - All arithmetic is modulo 2^ADR_W; wrap-around is silent.
- Completion: the final write is the one that makes wr[i]==cnt for every lane. FIN follows on the next cycle, so done coincides with that final wrEn cycle + 1.
- Data order within a lane is preserved. Writes are never dropped or duplicated.

Test Plan:
- Reset mid-RUN with lane FIFOs holding data, then rstn released -> all outputs 0; no wrEn; FSM IDLE; a new start runs cleanly from empty state.
- N=4, base=10, cnt=1, all four lanes valid in the same cycle with data 0xA0..0xA3 -> four consecutive wrEn cycles at addresses 10, 14, 18, 22 with data 0xA0..0xA3; done one cycle after the last write.
- cnt=3, only lane 2 valid every cycle with data 1, 2, 3 -> writes to base+8, +9, +10 in order. The first wrEn appears 2 cycles after acceptance. inReady[2] drops after the third accept, and a 4th inValid is ignored.
- All lanes streaming continuously, cnt=6, DEPTH=4 -> FIFOs fill and inReady deasserts on full. Grants strictly rotate 0,1,2,3. Exactly 24 writes issued, each lane's data in order, then a single done pulse.
- base=126, cnt=3, lane 0 only -> addresses 126, 127, 0 (wrap-around).
- cnt=0 start -> no wrEn; busy for one cycle; done pulses 2 cycles after start. A start pulsed during RUN has no effect.
